tft_pattern_source: RTL

Pixel source that sits directly upstream of the SPI TFT controller, driving its framebufferData bus and advancing one pixel per framebufferClk rising edge. It walks a WIDTH x HEIGHT raster in row-major order and generates RGB565 test content: colour bars, a checkerboard, a solid colour, or a bouncing box over colour bars. It also exports raster position and frame status for debug and overlay use.

---
 rtl/tft_pattern_source_pkg.sv | 40 ++++
 rtl/tft_pattern_source_if.sv | 22 ++
 rtl/tft_pattern_source_box_mover.sv | 42 ++++
 rtl/tft_pattern_source.sv | 137 +++++++++++++
 4 files changed

// File: rtl/tft_pattern_source_pkg.sv
// Shared definitions for the TFT test-pattern source: pattern modes, bar palette
// and default raster geometry.
package tft_pkg;

  localparam int unsigned DEF_WIDTH  = 240;
  localparam int unsigned DEF_HEIGHT = 320;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  localparam logic [15:0] COL_WHITE   = 16'hFFFF;
  localparam logic [15:0] COL_YELLOW  = 16'hFFE0;
  localparam logic [15:0] COL_CYAN    = 16'h07FF;
  localparam logic [15:0] COL_GREEN   = 16'h07E0;
  localparam logic [15:0] COL_MAGENTA = 16'hF81F;
  localparam logic [15:0] COL_RED     = 16'hF800;
  localparam logic [15:0] COL_BLUE    = 16'h001F;
  localparam logic [15:0] COL_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] col;
    case (idx)
      3'd0:    col = COL_WHITE;
      3'd1:    col = COL_YELLOW;
      3'd2:    col = COL_CYAN;
      3'd3:    col = COL_GREEN;
      3'd4:    col = COL_MAGENTA;
      3'd5:    col = COL_RED;
      3'd6:    col = COL_BLUE;
      3'd7:    col = COL_BLACK;
      default: col = COL_BLACK;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/tft_pattern_source_if.sv
// Pixel-bus bundle between the pattern source (master) and the TFT controller
// plus debug consumers (slave).
interface tft_pattern_source_if;
  logic [1:0]  mode;
  logic [15:0] solid_color;
  logic        framebufferClk;
  logic [15:0] framebufferData;
  logic [8:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    input  mode, solid_color, framebufferClk,
    output framebufferData, pixel_x, pixel_y, frame_start, frame_count
  );

  modport slave (
    output mode, solid_color, framebufferClk,
    input  framebufferData, pixel_x, pixel_y, frame_start, frame_count
  );
endinterface

// File: rtl/tft_pattern_source_box_mover.sv
// One axis of the bouncing box: steps once per enable, reversing at 0 and LIMIT
// with the reversal and the first step back taken in the same update.
module tft_box_mover #(
  parameter int unsigned LIMIT = 208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_step,
  output logic [8:0] o_pos
);

  localparam logic [8:0] LIM = 9'(LIMIT);

  logic [8:0] r_pos;
  logic       r_dir_neg;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos     <= 9'd0;
      r_dir_neg <= 1'b0;
    end else if (i_step) begin
      if (!r_dir_neg) begin
        if (r_pos == LIM) begin
          r_dir_neg <= 1'b1;
          r_pos     <= r_pos - 9'd1;
        end else begin
          r_pos <= r_pos + 9'd1;
        end
      end else begin
        if (r_pos == 9'd0) begin
          r_dir_neg <= 1'b0;
          r_pos     <= 9'd1;
        end else begin
          r_pos <= r_pos - 9'd1;
        end
      end
    end
  end

  assign o_pos = r_pos;

endmodule

// File: rtl/tft_pattern_source.sv
// RGB565 test-pattern source for the SPI TFT controller: walks the raster one
// pixel per framebufferClk rising edge and renders bars/checker/solid/box.
module tft_pattern_source
  import tft_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned HEIGHT       = DEF_HEIGHT,
  parameter int unsigned CHECK_LOG2   = 4,
  parameter int unsigned BOX_SIZE     = 32,
  parameter int unsigned IGNORE_EDGES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  tft_pattern_source_if.master bus
);

  localparam int unsigned BAR_W = WIDTH / 8;
  localparam int unsigned BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int unsigned SKW   = (IGNORE_EDGES > 0) ? $clog2(IGNORE_EDGES + 1) : 1;

  localparam logic [8:0]     X_MAX    = 9'(WIDTH - 1);
  localparam logic [8:0]     Y_MAX    = 9'(HEIGHT - 1);
  localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);
  localparam logic [SKW-1:0] SKIP_RST = SKW'(IGNORE_EDGES);

  logic           r_fbclk_q;
  logic [SKW-1:0] r_skip;
  logic [8:0]     r_x;
  logic [8:0]     r_y;
  logic [2:0]     r_bar_idx;
  logic [BCW-1:0] r_bar_cnt;
  logic [15:0]    r_frame_count;
  logic           r_frame_start;
  mode_e          r_active_mode;
  logic [15:0]    r_data;

  logic        w_edge;
  logic        w_adv;
  logic        w_wrap;
  logic [8:0]  w_box_x;
  logic [8:0]  w_box_y;
  logic        w_in_box;
  logic [15:0] w_bar;
  logic [15:0] w_pix;

  assign w_edge = bus.framebufferClk & ~r_fbclk_q;
  assign w_adv  = w_edge & (r_skip == {SKW{1'b0}});
  assign w_wrap = w_adv & (r_x == X_MAX) & (r_y == Y_MAX);

  tft_box_mover #(.LIMIT(WIDTH - BOX_SIZE)) u_box_x (
    .clk    (clk),
    .reset  (reset),
    .i_step (w_wrap),
    .o_pos  (w_box_x)
  );

  tft_box_mover #(.LIMIT(HEIGHT - BOX_SIZE)) u_box_y (
    .clk    (clk),
    .reset  (reset),
    .i_step (w_wrap),
    .o_pos  (w_box_y)
  );

  always_comb begin
    w_bar    = bar_color(r_bar_idx);
    w_in_box = ({1'b0, w_box_x} <= {1'b0, r_x}) &&
               ({1'b0, r_x} < ({1'b0, w_box_x} + 10'(BOX_SIZE))) &&
               ({1'b0, w_box_y} <= {1'b0, r_y}) &&
               ({1'b0, r_y} < ({1'b0, w_box_y} + 10'(BOX_SIZE)));
    w_pix    = w_bar;
    case (r_active_mode)
      MODE_BARS:  w_pix = w_bar;
      MODE_CHECK: w_pix = (r_x[CHECK_LOG2] ^ r_y[CHECK_LOG2]) ? COL_BLACK : COL_WHITE;
      MODE_SOLID: w_pix = bus.solid_color;
      MODE_BOX: begin
        if (w_in_box) begin
          w_pix = bus.solid_color;
        end else begin
          w_pix = w_bar;
        end
      end
      default:    w_pix = w_bar;
    endcase
  end

  // The bar index tracks x through a bar counter and an in-bar counter, so no divider is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fbclk_q     <= 1'b0;
      r_skip        <= SKIP_RST;
      r_x           <= 9'd0;
      r_y           <= 9'd0;
      r_bar_idx     <= 3'd0;
      r_bar_cnt     <= {BCW{1'b0}};
      r_frame_count <= 16'd0;
      r_frame_start <= 1'b0;
      r_active_mode <= mode_e'(bus.mode);
      r_data        <= COL_WHITE;
    end else begin
      r_fbclk_q     <= bus.framebufferClk;
      r_frame_start <= w_wrap;
      r_data        <= w_pix;
      if (w_edge && (r_skip != {SKW{1'b0}})) begin
        r_skip <= r_skip - SKW'(1);
      end
      if (w_adv) begin
        if (r_x != X_MAX) begin
          r_x <= r_x + 9'd1;
          if (r_bar_cnt == BAR_LAST) begin
            r_bar_cnt <= {BCW{1'b0}};
            r_bar_idx <= r_bar_idx + 3'd1;
          end else begin
            r_bar_cnt <= r_bar_cnt + BCW'(1);
          end
        end else begin
          r_x       <= 9'd0;
          r_bar_idx <= 3'd0;
          r_bar_cnt <= {BCW{1'b0}};
          if (r_y != Y_MAX) begin
            r_y <= r_y + 9'd1;
          end else begin
            r_y           <= 9'd0;
            r_frame_count <= r_frame_count + 16'd1;
            r_active_mode <= mode_e'(bus.mode);
          end
        end
      end
    end
  end

  assign bus.framebufferData = r_data;
  assign bus.pixel_x         = r_x;
  assign bus.pixel_y         = r_y;
  assign bus.frame_start     = r_frame_start;
  assign bus.frame_count     = r_frame_count;

endmodule
